// File: rtl/vend_pkg.sv
// Shared types and helpers for the parametrised vending controller:
// FSM state encoding, factory price table and keypad decode functions.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_SEL,
    S_WAIT_PAY,
    S_VEND,
    S_REFUND
  } vend_state_t;

  localparam int unsigned BASE_PRICE = 100;

  // Factory prices by key position; row 0 is key A, column 0 is key 1.
  function automatic int unsigned default_price(input int unsigned row, input int unsigned col);
    if (row == 0 && col == 0) return 100;
    if (row == 0 && col == 2) return 150;
    if (row == 1 && col == 0) return 250;
    if (row == 1 && col == 3) return 175;
    if (row == 3 && col == 2) return 200;
    return BASE_PRICE;
  endfunction

  function automatic logic onehot_valid(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) n++;
    end
    return (n == 1);
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vend_ctrl_param_if.sv
// Front-end bundle between coin acceptor/keypad and the vending controller.
interface vend_ctrl_param_if
  import vend_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MONEY_W = 16,
  parameter int SEL_W   = $clog2(ROWS * COLS)
);
  // Every strobe is a single-cycle pulse with no back-pressure: inputs are sampled on
  // each rising edge, all outputs are registered and pulses last exactly one cycle.
  logic               coin_valid;
  logic [MONEY_W-1:0] coin_value;
  logic [ROWS-1:0]    row_key;
  logic [COLS-1:0]    col_key;
  logic               cancel;
  logic               price_wr_en;
  logic [SEL_W-1:0]   price_wr_addr;
  logic [MONEY_W-1:0] price_wr_data;

  logic [MONEY_W-1:0] credit;
  logic [MONEY_W-1:0] price;
  logic [SEL_W-1:0]   selection;
  logic [MONEY_W-1:0] change;
  logic               change_valid;
  logic               success;
  logic               sel_error;
  logic               coin_reject;
  logic               timeout;
  vend_state_t        state_dbg;

  modport master (
    output coin_valid, coin_value, row_key, col_key, cancel,
           price_wr_en, price_wr_addr, price_wr_data,
    input  credit, price, selection, change, change_valid,
           success, sel_error, coin_reject, timeout, state_dbg
  );

  modport slave (
    input  coin_valid, coin_value, row_key, col_key, cancel,
           price_wr_en, price_wr_addr, price_wr_data,
    output credit, price, selection, change, change_valid,
           success, sel_error, coin_reject, timeout, state_dbg
  );

endinterface

// File: rtl/vend_price_table.sv
// Price register file: one entry per key position, synchronous write,
// asynchronous read, reloaded with factory prices on reset.
module vend_price_table
  import vend_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MONEY_W = 16,
  parameter int SEL_W   = $clog2(ROWS * COLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [SEL_W-1:0]   wr_addr,
  input  logic [MONEY_W-1:0] wr_data,
  input  logic [SEL_W-1:0]   rd_addr,
  output logic [MONEY_W-1:0] rd_data
);

  localparam int ENTRIES = ROWS * COLS;

  logic [MONEY_W-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mem[r*COLS+c] <= MONEY_W'(default_price(r, c));
        end
      end
    end else if (wr_en && (int'(wr_addr) < ENTRIES)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (int'(rd_addr) < ENTRIES) ? mem[rd_addr] : '0;

endmodule

// File: rtl/vend_ctrl_param.sv
// Vending controller: keypad selection FSM, saturating coin credit,
// cancel and idle-timeout refunds; every output is registered.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int MONEY_W     = 16,
  parameter int MAX_CREDIT  = 1000,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic              clk,
  input logic              reset,
  vend_ctrl_param_if.slave bus
);

  localparam int SEL_W = $clog2(ROWS * COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  vend_state_t        state, state_n;
  logic [MONEY_W-1:0] credit_q, credit_n, price_q, price_n, change_q, change_n;
  logic [SEL_W-1:0]   sel_q, sel_n;
  logic [ROW_W-1:0]   row_q, row_n;
  logic [TMR_W-1:0]   timer_q, timer_n;
  logic change_valid_q, change_valid_n, success_q, success_n;
  logic sel_error_q, sel_error_n, coin_reject_q, coin_reject_n, timeout_q, timeout_n;

  logic               accepting, coin_ok, activity, timer_hit, price_we, do_vend;
  logic               row_any, col_any, key_bad, row_ok, col_ok;
  logic [MONEY_W:0]   coin_sum;
  logic [MONEY_W-1:0] credit_post, table_price, vend_price;
  logic [ROW_W-1:0]   row_idx;
  logic [COL_W-1:0]   col_idx;
  logic [SEL_W-1:0]   sel_cand;

  assign accepting = (state == S_IDLE) || (state == S_ROW_SEL) || (state == S_WAIT_PAY);

  // Coin is added before any decision so a paying coin and a key can land together.
  assign coin_sum    = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign coin_ok     = bus.coin_valid && accepting && !bus.cancel &&
                       (coin_sum <= (MONEY_W+1)'(MAX_CREDIT));
  assign credit_post = coin_ok ? coin_sum[MONEY_W-1:0] : credit_q;

  assign row_any = |bus.row_key;
  assign col_any = |bus.col_key;
  assign key_bad = (row_any && col_any) ||
                   (row_any && !onehot_valid(8'(bus.row_key))) ||
                   (col_any && !onehot_valid(8'(bus.col_key)));
  assign row_ok  = row_any && !key_bad;
  assign col_ok  = col_any && !key_bad;
  assign row_idx = ROW_W'(onehot_idx(8'(bus.row_key)));
  assign col_idx = COL_W'(onehot_idx(8'(bus.col_key)));
  assign sel_cand = SEL_W'(row_q) * SEL_W'(COLS) + SEL_W'(col_idx);

  assign activity  = bus.coin_valid || row_any || col_any || bus.cancel;
  assign timer_hit = accepting && (credit_q != '0) && !activity &&
                     (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  assign price_we  = bus.price_wr_en && (state == S_IDLE) && (credit_q == '0);

  vend_price_table #(
    .ROWS(ROWS), .COLS(COLS), .MONEY_W(MONEY_W), .SEL_W(SEL_W)
  ) u_price_table (
    .clk(clk), .reset(reset),
    .wr_en(price_we), .wr_addr(bus.price_wr_addr), .wr_data(bus.price_wr_data),
    .rd_addr(sel_cand), .rd_data(table_price)
  );

  always_comb begin
    state_n        = state;
    credit_n       = credit_post;
    price_n        = price_q;
    sel_n          = sel_q;
    row_n          = row_q;
    change_n       = change_q;
    change_valid_n = 1'b0;
    success_n      = 1'b0;
    sel_error_n    = 1'b0;
    timeout_n      = 1'b0;
    coin_reject_n  = bus.coin_valid && !coin_ok;
    vend_price     = price_q;
    do_vend        = 1'b0;
    if (!accepting || (credit_q == '0) || activity || timer_hit) timer_n = '0;
    else timer_n = timer_q + TMR_W'(1);

    case (state)
      S_VEND: begin
        state_n  = S_IDLE;
        credit_n = '0;
        price_n  = '0;
      end
      S_REFUND: begin
        state_n  = S_IDLE;
        credit_n = '0;
      end
      default: begin
        if (bus.cancel) begin
          if (!((state == S_IDLE) && (credit_q == '0))) begin
            state_n        = S_REFUND;
            sel_n          = '0;
            price_n        = '0;
            change_n       = credit_q;
            change_valid_n = (credit_q != '0);
          end
        end else if (timer_hit) begin
          state_n        = S_REFUND;
          sel_n          = '0;
          price_n        = '0;
          change_n       = credit_q;
          change_valid_n = 1'b1;
          timeout_n      = 1'b1;
        end else if (key_bad) begin
          sel_error_n = 1'b1;
        end else begin
          case (state)
            S_IDLE: begin
              if (row_ok) begin
                state_n = S_ROW_SEL;
                row_n   = row_idx;
              end else if (col_ok) begin
                sel_error_n = 1'b1;
              end
            end
            S_ROW_SEL: begin
              if (col_ok) begin
                sel_n      = sel_cand;
                price_n    = table_price;
                vend_price = table_price;
                do_vend    = (credit_post >= table_price);
                if (!do_vend) state_n = S_WAIT_PAY;
              end else if (row_ok) begin
                state_n     = S_IDLE;
                sel_n       = '0;
                sel_error_n = 1'b1;
              end
            end
            S_WAIT_PAY: begin
              if (row_ok) begin
                state_n = S_ROW_SEL;
                row_n   = row_idx;
                sel_n   = '0;
                price_n = '0;
              end else if (col_ok) begin
                sel_error_n = 1'b1;
              end else begin
                do_vend = (credit_post >= price_q);
              end
            end
            default: ;
          endcase
        end
        // Credit stays visible during the vend cycle and is cleared on its exit.
        if (do_vend) begin
          state_n        = S_VEND;
          success_n      = 1'b1;
          change_valid_n = 1'b1;
          change_n       = credit_post - vend_price;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      credit_q       <= '0;
      price_q        <= '0;
      sel_q          <= '0;
      row_q          <= '0;
      change_q       <= '0;
      timer_q        <= '0;
      change_valid_q <= 1'b0;
      success_q      <= 1'b0;
      sel_error_q    <= 1'b0;
      coin_reject_q  <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state          <= state_n;
      credit_q       <= credit_n;
      price_q        <= price_n;
      sel_q          <= sel_n;
      row_q          <= row_n;
      change_q       <= change_n;
      timer_q        <= timer_n;
      change_valid_q <= change_valid_n;
      success_q      <= success_n;
      sel_error_q    <= sel_error_n;
      coin_reject_q  <= coin_reject_n;
      timeout_q      <= timeout_n;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.price        = price_q;
  assign bus.selection    = sel_q;
  assign bus.change       = change_q;
  assign bus.change_valid = change_valid_q;
  assign bus.success      = success_q;
  assign bus.sel_error    = sel_error_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.timeout      = timeout_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: table of single-cycle vectors checked through an
// expected-value queue, plus hand-written timeout and reset sequences.
module tb_vend_ctrl_param;
  import vend_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int MW   = 16;
  localparam int TO   = 1000;
  localparam int EW   = 57;

  // Expected-flag bits: {change_valid, success, sel_error, coin_reject, timeout}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_CV   = 5'b10000;
  localparam logic [4:0] F_VEND = 5'b11000;
  localparam logic [4:0] F_SE   = 5'b00100;
  localparam logic [4:0] F_CR   = 5'b00010;

  localparam logic [3:0] K_A = 4'b0001, K_B = 4'b0010, K_D = 4'b1000;
  localparam logic [3:0] K_1 = 4'b0001, K_3 = 4'b0100, K_4 = 4'b1000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vend_ctrl_param_if #(.ROWS(ROWS), .COLS(COLS), .MONEY_W(MW)) bus ();

  vend_ctrl_param #(
    .ROWS(ROWS), .COLS(COLS), .MONEY_W(MW), .MAX_CREDIT(1000), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string          name;
    logic           coin_v;
    logic [MW-1:0]  coin;
    logic [3:0]     row;
    logic [3:0]     col;
    logic           cancel;
    logic           pw_en;
    logic [3:0]     pw_addr;
    logic [MW-1:0]  pw_data;
    logic [EW-1:0]  exp;
  } vec_t;

  vec_t          tbl[$];
  logic [EW-1:0] exp_q[$];

  function automatic void add(input string n, input int coin, input logic [3:0] r,
                              input logic [3:0] c, input logic can, input int pwa,
                              input int pwd, input int e_cr, input int e_pr,
                              input int e_sel, input int e_chg, input logic [4:0] fl);
    vec_t v;
    v.name    = n;
    v.coin_v  = (coin > 0);
    v.coin    = MW'(coin);
    v.row     = r;
    v.col     = c;
    v.cancel  = can;
    v.pw_en   = (pwa >= 0);
    v.pw_addr = 4'(pwa);
    v.pw_data = MW'(pwd);
    v.exp     = {MW'(e_cr), MW'(e_pr), 4'(e_sel), MW'(e_chg), fl};
    tbl.push_back(v);
  endfunction

  // Driver: inputs change on the falling edge, outputs are read 1ns after the rising edge.
  task automatic apply(input logic cv, input logic [MW-1:0] cval, input logic [3:0] r,
                       input logic [3:0] c, input logic can, input logic pwe,
                       input logic [3:0] pa, input logic [MW-1:0] pd);
    @(negedge clk);
    bus.coin_valid    = cv;
    bus.coin_value    = cval;
    bus.row_key       = r;
    bus.col_key       = c;
    bus.cancel        = can;
    bus.price_wr_en   = pwe;
    bus.price_wr_addr = pa;
    bus.price_wr_data = pd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, req);
    end
  endtask

  // Scoreboard: pop the oldest expectation and compare against current outputs.
  task automatic compare_out(input string n);
    logic [EW-1:0] e, a;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: expected queue empty", n);
    end else begin
      e = exp_q.pop_front();
      a = {bus.credit, bus.price, bus.selection, bus.change, bus.change_valid,
           bus.success, bus.sel_error, bus.coin_reject, bus.timeout};
      if (!e[4]) begin
        e[20:5] = '0;
        a[20:5] = '0;
      end
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got cr=%0d pr=%0d sel=%0d chg=%0d fl=%b expected cr=%0d pr=%0d sel=%0d chg=%0d fl=%b",
                 n, a[56:41], a[40:25], a[24:21], a[20:5], a[4:0],
                 e[56:41], e[40:25], e[24:21], e[20:5], e[4:0]);
      end
    end
  endtask

  initial begin
    int got;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.coin_valid = 1'b0; bus.coin_value = '0; bus.row_key = '0; bus.col_key = '0;
    bus.cancel = 1'b0; bus.price_wr_en = 1'b0; bus.price_wr_addr = '0; bus.price_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_credit", int'(bus.credit), 0);
    check("rst_flags", int'({bus.change_valid, bus.success, bus.sel_error, bus.coin_reject, bus.timeout}), 0);
    check("rst_state", int'(bus.state_dbg), int'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;

    //  name          coin row  col  can pwa pwd  credit price sel chg flags
    add("t1_c25a",      25, 0,   0,   0, -1, 0,     25,   0,  0,  0, F_NONE);
    add("t1_c25b",      25, 0,   0,   0, -1, 0,     50,   0,  0,  0, F_NONE);
    add("t1_c25c",      25, 0,   0,   0, -1, 0,     75,   0,  0,  0, F_NONE);
    add("t1_c25d",      25, 0,   0,   0, -1, 0,    100,   0,  0,  0, F_NONE);
    add("t1_rowA",       0, K_A, 0,   0, -1, 0,    100,   0,  0,  0, F_NONE);
    add("t1_col1",       0, 0,   K_1, 0, -1, 0,    100, 100,  0,  0, F_VEND);
    add("t1_clear",      0, 0,   0,   0, -1, 0,      0,   0,  0,  0, F_NONE);
    add("t2_rowB",       0, K_B, 0,   0, -1, 0,      0,   0,  0,  0, F_NONE);
    add("t2_col4",       0, 0,   K_4, 0, -1, 0,      0, 175,  7,  0, F_NONE);
    add("t2_c100",     100, 0,   0,   0, -1, 0,    100, 175,  7,  0, F_NONE);
    add("t2_c75",       75, 0,   0,   0, -1, 0,    175, 175,  7,  0, F_VEND);
    add("t2_clear",      0, 0,   0,   0, -1, 0,      0,   0,  7,  0, F_NONE);
    add("t3_c100a",    100, 0,   0,   0, -1, 0,    100,   0,  7,  0, F_NONE);
    add("t3_c100b",    100, 0,   0,   0, -1, 0,    200,   0,  7,  0, F_NONE);
    add("t3_rowA",       0, K_A, 0,   0, -1, 0,    200,   0,  7,  0, F_NONE);
    add("t3_col3",       0, 0,   K_3, 0, -1, 0,    200, 150,  2, 50, F_VEND);
    add("t3_clear",      0, 0,   0,   0, -1, 0,      0,   0,  2,  0, F_NONE);
    add("t3_c100c",    100, 0,   0,   0, -1, 0,    100,   0,  2,  0, F_NONE);
    add("t3_c100d",    100, 0,   0,   0, -1, 0,    200,   0,  2,  0, F_NONE);
    add("t3_rowB",       0, K_B, 0,   0, -1, 0,    200,   0,  2,  0, F_NONE);
    add("t3_col1",       0, 0,   K_1, 0, -1, 0,    200, 250,  4,  0, F_NONE);
    add("t3_cancel",     0, 0,   0,   1, -1, 0,    200,   0,  0,200, F_CV);
    add("t3_clear",      0, 0,   0,   0, -1, 0,      0,   0,  0,  0, F_NONE);
    add("t4_rowA",       0, K_A, 0,   0, -1, 0,      0,   0,  0,  0, F_NONE);
    add("t4_rowA2",      0, K_A, 0,   0, -1, 0,      0,   0,  0,  0, F_SE);
    add("t4_col4_idle",  0, 0,   K_4, 0, -1, 0,      0,   0,  0,  0, F_SE);
    add("t4_multirow",   0, 4'b0011, 0, 0, -1, 0,    0,   0,  0,  0, F_SE);
    add("t4_c100a",    100, 0,   0,   0, -1, 0,    100,   0,  0,  0, F_NONE);
    add("t4_c100b",    100, 0,   0,   0, -1, 0,    200,   0,  0,  0, F_NONE);
    add("t4_rowA3",      0, K_A, 0,   0, -1, 0,    200,   0,  0,  0, F_NONE);
    add("t4_col4",       0, 0,   K_4, 0, -1, 0,    200, 100,  3,100, F_VEND);
    add("t4_clear",      0, 0,   0,   0, -1, 0,      0,   0,  3,  0, F_NONE);
    add("t4_rowcol",     0, K_A, K_1, 0, -1, 0,      0,   0,  3,  0, F_SE);
    for (int i = 1; i <= 9; i++)
      add("t6_fill",   100, 0,   0,   0, -1, 0,  100*i,   0,  3,  0, F_NONE);
    add("t6_over",     200, 0,   0,   0, -1, 0,    900,   0,  3,  0, F_CR);
    add("t6_pw_busy",    0, 0,   0,   0, 14, 300,  900,   0,  3,  0, F_NONE);
    add("t6_at_max",   100, 0,   0,   0, -1, 0,   1000,   0,  3,  0, F_NONE);
    add("t6_rowD",       0, K_D, 0,   0, -1, 0,   1000,   0,  3,  0, F_NONE);
    add("t6_col3_dflt",  0, 0,   K_3, 0, -1, 0,   1000, 200, 14,800, F_VEND);
    add("t6_coin_vend", 25, 0,   0,   0, -1, 0,      0,   0, 14,  0, F_CR);
    add("t6_pw_idle",    0, 0,   0,   0, 14, 300,    0,   0, 14,  0, F_NONE);
    add("t6_rowD2",      0, K_D, 0,   0, -1, 0,      0,   0, 14,  0, F_NONE);
    add("t6_col3_new",   0, 0,   K_3, 0, -1, 0,      0, 300, 14,  0, F_NONE);
    add("t6_cancel0",    0, 0,   0,   1, -1, 0,      0,   0,  0,  0, F_NONE);
    add("t6_clear",      0, 0,   0,   0, -1, 0,      0,   0,  0,  0, F_NONE);
    add("t6_cancel_idle",0, 0,   0,   1, -1, 0,      0,   0,  0,  0, F_NONE);

    for (int i = 0; i < tbl.size(); i++) begin
      exp_q.push_back(tbl[i].exp);
      apply(tbl[i].coin_v, tbl[i].coin, tbl[i].row, tbl[i].col, tbl[i].cancel,
            tbl[i].pw_en, tbl[i].pw_addr, tbl[i].pw_data);
      compare_out(tbl[i].name);
    end

    // Idle timeout: refund after exactly TO quiet cycles following the coin
    apply(1'b1, MW'(100), '0, '0, 1'b0, 1'b0, '0, '0);
    check("to_credit", int'(bus.credit), 100);
    got = -1;
    for (int k = 1; k <= TO + 50; k++) begin
      idle();
      if (bus.timeout) begin
        got = k;
        break;
      end
    end
    check("to_latency", got, TO);
    check("to_change", int'(bus.change), 100);
    check("to_cv", int'(bus.change_valid), 1);
    check("to_state", int'(bus.state_dbg), int'(S_REFUND));
    idle();
    check("to_pulse_width", int'(bus.timeout), 0);
    check("to_credit_clr", int'(bus.credit), 0);

    // Reset while waiting for payment, then factory prices must be back
    apply(1'b1, MW'(50), '0, '0, 1'b0, 1'b0, '0, '0);
    apply(1'b0, '0, K_B, '0, 1'b0, 1'b0, '0, '0);
    apply(1'b0, '0, '0, K_4, 1'b0, 1'b0, '0, '0);
    check("wp_price", int'(bus.price), 175);
    check("wp_state", int'(bus.state_dbg), int'(S_WAIT_PAY));
    @(negedge clk);
    bus.col_key = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_outs", int'({bus.credit, bus.price, bus.selection}), 0);
    check("mid_rst_flags", int'({bus.change_valid, bus.success, bus.sel_error, bus.coin_reject, bus.timeout}), 0);
    check("mid_rst_state", int'(bus.state_dbg), int'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;
    apply(1'b1, MW'(100), '0, '0, 1'b0, 1'b0, '0, '0);
    apply(1'b1, MW'(100), '0, '0, 1'b0, 1'b0, '0, '0);
    apply(1'b0, '0, K_D, '0, 1'b0, 1'b0, '0, '0);
    apply(1'b0, '0, '0, K_3, 1'b0, 1'b0, '0, '0);
    check("rst_tbl_price", int'(bus.price), 200);
    check("rst_tbl_success", int'(bus.success), 1);
    check("rst_tbl_change", int'(bus.change), 0);
    check("rst_tbl_sel", int'(bus.selection), 14);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
